// File: rtl/icache_direct_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_direct_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  // mem_ctrl request encodings
  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;

  // mem_ctrl transfer lengths (bytes - 1)
  localparam logic [1:0] LEN_NONE = 2'd0;
  localparam logic [1:0] LEN_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave: the cache's view. master: the fetcher / mem_ctrl side.
interface icache_direct_if;
  import icache_direct_pkg::*;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_flush;
  logic                  if_valid;
  logic [INST_WIDTH-1:0] if_inst;
  logic                  if_busy;

  logic [1:0]            mem_rw_flag;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_len;
  logic [INST_WIDTH-1:0] mem_data;
  logic                  mem_busy;
  logic                  mem_done;

  modport slave (
    input  if_req, if_pc, if_flush, mem_data, mem_busy, mem_done,
    output if_valid, if_inst, if_busy, mem_rw_flag, mem_addr, mem_len
  );

  modport master (
    output if_req, if_pc, if_flush, mem_data, mem_busy, mem_done,
    input  if_valid, if_inst, if_busy, mem_rw_flag, mem_addr, mem_len
  );

endinterface

// File: rtl/icache_direct_array.sv
// Storage for the cache: valid vector, tag array and data array.
// Combinational read port, single synchronous write port.
module icache_direct_array
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [INST_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [INST_WIDTH-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [INST_WIDTH-1:0] data_q [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage: written on fill.
  // NOTE: no reset on the arrays -- contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Hits deliver the word one cycle after the request; misses do a single
// word read from mem_ctrl, fill the line (except I/O space) and deliver.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  icache_direct_if.slave  bus
);

  localparam int TAG_BITS = 18 - 2 - INDEX_BITS;

  state_e                state_q, state_d;
  logic [31:2]           pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [1:0]            rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            len_q, len_d;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INST_WIDTH-1:0] rd_data;
  logic                  hit;
  logic                  fill;

  // Byte offset and mem_busy carry no information for a held word read.
  logic                  unused_inputs;
  assign unused_inputs = ^{bus.if_pc[1:0], bus.mem_busy};

  icache_direct_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (bus.if_pc[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill && rdy),
    .wr_index (pc_q[INDEX_BITS+1:2]),
    .wr_tag   (pc_q[17:INDEX_BITS+2]),
    .wr_data  (bus.mem_data)
  );

  // I/O space (pc[17]=1) never hits, so it is always re-read from memory.
  assign hit = rd_valid && (rd_tag == bus.if_pc[17:INDEX_BITS+2]) && !bus.if_pc[17];

  // Next-state and next-output logic for the fetch FSM.
  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    valid_d = 1'b0;
    inst_d  = inst_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    len_d   = len_q;
    fill    = 1'b0;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (bus.if_req && !bus.if_flush) begin
          if (hit) begin
            valid_d = 1'b1;
            inst_d  = rd_data;
          end else begin
            state_d = MISS;
            pc_d    = bus.if_pc[31:2];
            rw_d    = MEM_RD;
            addr_d  = {bus.if_pc[31:2], 2'b00};
            len_d   = LEN_WORD;
          end
        end
      end
      MISS: begin
        if (bus.if_flush) drop_d = 1'b1;
        if (bus.mem_done) begin
          fill    = !pc_q[17];
          inst_d  = bus.mem_data;
          valid_d = !(drop_q || bus.if_flush);
          rw_d    = MEM_IDLE;
          len_d   = LEN_NONE;
          state_d = RESP;
        end
      end
      RESP: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; rdy=0 freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      rw_q    <= MEM_IDLE;
      addr_q  <= '0;
      len_q   <= LEN_NONE;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  // A redirect during the delivery cycle of a miss cancels that delivery.
  assign bus.if_valid    = valid_q && !((state_q == RESP) && bus.if_flush);
  assign bus.if_inst     = inst_q;
  assign bus.if_busy     = (state_q != IDLE);
  assign bus.mem_rw_flag = rw_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_len     = len_q;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios followed by a
// randomized fetch stream, all checked against a line-level cache model.
module tb_icache_direct;

  logic clk;
  logic rst;
  logic rdy;

  icache_direct_if bus ();

  icache_direct #(.INDEX_BITS(7)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Reference model: one entry per line, filled from the backing memory.
  bit          m_valid [128];
  logic [8:0]  m_tag   [128];
  logic [31:0] m_data  [128];

  // Backing memory contents; address 0 holds 0x00000013.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h0000_0013;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[pc[8:2]] && (m_tag[pc[8:2]] == pc[17:9]) && !pc[17];
  endfunction

  // One complete fetch: request, optional memory service, delivery.
  // flush_mode: 0 none, 1 flush during MISS, 2 flush in the delivery cycle.
  task automatic run_fetch(input logic [31:0] pc, input int wait_cycles,
                           input int busy_cycles, input int flush_mode,
                           input string name);
    logic [31:0] line_addr;
    logic [31:0] exp_word;
    bit          exp_hit;
    bit          exp_valid;
    line_addr = {pc[31:2], 2'b00};
    exp_hit   = m_hit(pc);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.if_pc  = $urandom();
    if (exp_hit) begin
      exp_word = m_data[pc[8:2]];
      assertions++;
      if (bus.if_valid !== 1'b1 || bus.if_inst !== exp_word ||
          bus.mem_rw_flag !== 2'b00 || bus.if_busy !== 1'b0) begin
        failures++;
        $display("FAIL %s hit pc=%h: valid=%b inst=%h rw=%b busy=%b, want valid=1 inst=%h rw=00 busy=0",
                 name, pc, bus.if_valid, bus.if_inst, bus.mem_rw_flag, bus.if_busy, exp_word);
      end
      @(negedge clk);
      assertions++;
      if (bus.if_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s hit pulse pc=%h: valid=%b, want 0", name, pc, bus.if_valid);
      end
    end else begin
      assertions++;
      if (bus.mem_rw_flag !== 2'b01 || bus.mem_addr !== line_addr ||
          bus.mem_len !== 2'd3 || bus.if_busy !== 1'b1 || bus.if_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s miss request pc=%h: rw=%b addr=%h len=%0d busy=%b valid=%b, want rw=01 addr=%h len=3 busy=1 valid=0",
                 name, pc, bus.mem_rw_flag, bus.mem_addr, bus.mem_len, bus.if_busy, bus.if_valid, line_addr);
      end
      for (int i = 0; i < wait_cycles; i++) begin
        bus.mem_busy = (i < busy_cycles);
        bus.if_flush = (flush_mode == 1) && (i == 0);
        @(negedge clk);
        bus.mem_busy = 1'b0;
        bus.if_flush = 1'b0;
        assertions++;
        if (bus.mem_rw_flag !== 2'b01 || bus.mem_addr !== line_addr ||
            bus.mem_len !== 2'd3 || bus.if_valid !== 1'b0 || bus.if_busy !== 1'b1) begin
          failures++;
          $display("FAIL %s miss hold cycle %0d: rw=%b addr=%h len=%0d valid=%b busy=%b, want rw=01 addr=%h len=3 valid=0 busy=1",
                   name, i, bus.mem_rw_flag, bus.mem_addr, bus.mem_len, bus.if_valid, bus.if_busy, line_addr);
        end
      end
      bus.mem_done = 1'b1;
      bus.mem_data = word_at(line_addr);
      bus.if_flush = (flush_mode == 1) && (wait_cycles == 0);
      @(negedge clk);
      bus.mem_done = 1'b0;
      bus.mem_data = $urandom();
      bus.if_flush = 1'b0;
      exp_word = word_at(line_addr);
      if (!pc[17]) begin
        m_valid[pc[8:2]] = 1'b1;
        m_tag[pc[8:2]]   = pc[17:9];
        m_data[pc[8:2]]  = exp_word;
      end
      if (flush_mode == 2) begin
        bus.if_flush = 1'b1;
        #1;
      end
      exp_valid = (flush_mode == 0);
      assertions++;
      if (bus.if_valid !== exp_valid || (exp_valid && bus.if_inst !== exp_word) ||
          bus.mem_rw_flag !== 2'b00 || bus.if_busy !== 1'b1) begin
        failures++;
        $display("FAIL %s delivery pc=%h: valid=%b inst=%h rw=%b busy=%b, want valid=%b inst=%h rw=00 busy=1",
                 name, pc, bus.if_valid, bus.if_inst, bus.mem_rw_flag, bus.if_busy, exp_valid, exp_word);
      end
      @(negedge clk);
      bus.if_flush = 1'b0;
      assertions++;
      if (bus.if_valid !== 1'b0 || bus.if_busy !== 1'b0) begin
        failures++;
        $display("FAIL %s return to idle: valid=%b busy=%b, want 0 0", name, bus.if_valid, bus.if_busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    bus.if_req = 1'b0; bus.if_pc = '0; bus.if_flush = 1'b0;
    bus.mem_data = '0; bus.mem_busy = 1'b0; bus.mem_done = 1'b0;
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    assertions++;
    if (bus.if_valid !== 1'b0 || bus.if_inst !== 32'h0 || bus.if_busy !== 1'b0 ||
        bus.mem_rw_flag !== 2'b00 || bus.mem_addr !== 32'h0 || bus.mem_len !== 2'd0) begin
      failures++;
      $display("FAIL reset: valid=%b inst=%h busy=%b rw=%b addr=%h len=%0d, want all zero",
               bus.if_valid, bus.if_inst, bus.if_busy, bus.mem_rw_flag, bus.mem_addr, bus.mem_len);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_hit_conflict();
    run_fetch(32'h0000_0000, 3, 0, 0, "cold_miss");
    run_fetch(32'h0000_0000, 0, 0, 0, "hit");
    run_fetch(32'h0000_0200, 2, 0, 0, "conflict_new_tag");
    run_fetch(32'h0000_0000, 1, 0, 0, "conflict_old_tag");
  endtask

  task automatic test_flush_miss();
    run_fetch(32'h0000_0044, 3, 0, 1, "flush_in_miss");
    run_fetch(32'h0000_0044, 0, 0, 0, "flush_in_miss_rehit");
    run_fetch(32'h0000_0108, 2, 0, 2, "flush_in_resp");
    run_fetch(32'h0000_0108, 0, 0, 0, "flush_in_resp_rehit");
  endtask

  task automatic test_mem_busy();
    run_fetch(32'h0000_1008, 6, 5, 0, "mem_busy");
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] pc;
    pc = 32'h0003_0000;
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    @(negedge clk);
    bus.if_req = 1'b0;
    assertions++;
    if (bus.mem_rw_flag !== 2'b01 || bus.mem_addr !== pc || bus.if_busy !== 1'b1) begin
      failures++;
      $display("FAIL rdy io miss request: rw=%b addr=%h busy=%b, want rw=01 addr=%h busy=1",
               bus.mem_rw_flag, bus.mem_addr, bus.if_busy, pc);
    end
    rdy = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_data = word_at(pc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      assertions++;
      if (bus.mem_rw_flag !== 2'b01 || bus.mem_addr !== pc || bus.mem_len !== 2'd3 ||
          bus.if_busy !== 1'b1 || bus.if_valid !== 1'b0) begin
        failures++;
        $display("FAIL rdy frozen cycle %0d: rw=%b addr=%h len=%0d busy=%b valid=%b, want rw=01 addr=%h len=3 busy=1 valid=0",
                 i, bus.mem_rw_flag, bus.mem_addr, bus.mem_len, bus.if_busy, bus.if_valid, pc);
      end
    end
    rdy = 1'b1;
    @(negedge clk);
    bus.mem_done = 1'b0;
    assertions++;
    if (bus.if_valid !== 1'b1 || bus.if_inst !== word_at(pc) || bus.mem_rw_flag !== 2'b00) begin
      failures++;
      $display("FAIL rdy io delivery: valid=%b inst=%h rw=%b, want valid=1 inst=%h rw=00",
               bus.if_valid, bus.if_inst, bus.mem_rw_flag, word_at(pc));
    end
    @(negedge clk);
    run_fetch(pc, 1, 0, 0, "io_rerequest_misses");
  endtask

  task automatic test_idle_flush();
    bus.if_req = 1'b1; bus.if_pc = 32'h0000_0044; bus.if_flush = 1'b1;
    @(negedge clk);
    bus.if_req = 1'b0; bus.if_flush = 1'b0;
    assertions++;
    if (bus.if_valid !== 1'b0 || bus.if_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_flush hit dropped: valid=%b busy=%b, want 0 0", bus.if_valid, bus.if_busy);
    end
    bus.if_req = 1'b1; bus.if_pc = 32'h0000_2010; bus.if_flush = 1'b1;
    @(negedge clk);
    bus.if_req = 1'b0; bus.if_flush = 1'b0;
    assertions++;
    if (bus.if_busy !== 1'b0 || bus.mem_rw_flag !== 2'b00) begin
      failures++;
      $display("FAIL idle_flush miss dropped: busy=%b rw=%b, want 0 00", bus.if_busy, bus.mem_rw_flag);
    end
    run_fetch(32'h0000_2010, 1, 0, 0, "idle_flush_then_miss");
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0000_0000; pcs[1] = 32'h0000_0044; pcs[2] = 32'h0000_1008;
    bus.if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.if_pc = pcs[i];
      @(negedge clk);
      assertions++;
      if (bus.if_valid !== 1'b1 || bus.if_inst !== m_data[pcs[i][8:2]] || bus.if_busy !== 1'b0) begin
        failures++;
        $display("FAIL back_to_back %0d pc=%h: valid=%b inst=%h busy=%b, want valid=1 inst=%h busy=0",
                 i, pcs[i], bus.if_valid, bus.if_inst, bus.if_busy, m_data[pcs[i][8:2]]);
      end
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    assertions++;
    if (bus.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back end: valid=%b, want 0", bus.if_valid);
    end
  endtask

  task automatic test_reset_mid_miss();
    bus.if_req = 1'b1; bus.if_pc = 32'h0000_4000;
    @(negedge clk);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    assertions++;
    if (bus.if_busy !== 1'b0 || bus.mem_rw_flag !== 2'b00 || bus.mem_addr !== 32'h0 ||
        bus.mem_len !== 2'd0 || bus.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_miss: busy=%b rw=%b addr=%h len=%0d valid=%b, want all zero",
               bus.if_busy, bus.mem_rw_flag, bus.mem_addr, bus.mem_len, bus.if_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    run_fetch(32'h0000_0044, 1, 0, 0, "after_reset_misses");
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int          wait_cycles;
    int          flush_mode;
    for (int n = 0; n < 120; n++) begin
      pc = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) pc = pc | 32'h0002_0000;
      if ($urandom_range(0, 3) == 0) pc = pc | ($urandom() & 32'hFFFC_0000);
      wait_cycles = $urandom_range(0, 4);
      flush_mode  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      run_fetch(pc, wait_cycles, $urandom_range(0, wait_cycles), flush_mode, "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_hit_conflict();
    test_flush_miss();
    test_mem_busy();
    test_rdy_freeze();
    test_idle_flush();
    test_back_to_back();
    test_reset_mid_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
